// File: rtl/maxpool_layer_pkg.sv
// Shared types and geometry for the 1x2 max-pool layer.
package maxpool_layer_pkg;
`include "num_data.v"

  localparam int DL   = `DATA_LEN;
  localparam int CH   = `CH_NUM;
  localparam int LEN  = `DATA_NUM;
  localparam int PLEN = `POOL_NUM;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  // Counter width holding G-1; a single group still needs one bit.
  function automatic int cnt_w(input int g);
    return (g > 1) ? $clog2(g) : 1;
  endfunction
endpackage

// File: rtl/max2.sv
// Combinational signed maximum of two data words.
module max2
  import maxpool_layer_pkg::*;
(
  input  logic signed [DL-1:0] i_a,
  input  logic signed [DL-1:0] i_b,
  output logic signed [DL-1:0] o_max
);

  assign o_max = (i_a >= i_b) ? i_a : i_b;

endmodule

// File: rtl/num_data.v
// Shared data geometry for the CNN pipeline stages.
`ifndef NUM_DATA_V
`define NUM_DATA_V
`define DATA_LEN 16
`define CH_NUM 32
`define DATA_NUM 12
`define POOL_NUM 6
`endif

// File: rtl/maxpool_layer.sv
// 1x2 signed max-pool over 32 channels, CPC channels per cycle; one stage
// register feeds CPC*6 comparators whose results land in q group by group.
module maxpool_layer
  import maxpool_layer_pkg::*;
#(
  parameter int CPC = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load,
  input  logic [CH*LEN*DL-1:0]   d,
  output logic                   valid,
  output logic [CH*PLEN*DL-1:0]  q
);

  localparam int G    = CH / CPC;
  localparam int CW   = cnt_w(G);
  localparam int GIN  = CPC * LEN * DL;
  localparam int GOUT = CPC * PLEN * DL;
  localparam logic [CW-1:0] LAST     = CW'(G - 1);
  localparam logic [CW-1:0] RD_START = (G > 1) ? CW'(1) : CW'(0);

  state_t                 r_state;
  state_t                 w_next;
  logic [CW-1:0]          r_rd_idx;
  logic [CW-1:0]          r_wr_idx;
  logic [GIN-1:0]         r_stage;
  logic [CH*PLEN*DL-1:0]  r_q;
  logic                   r_valid;

  logic [CW-1:0]          w_sel;
  logic [GIN-1:0]         w_grp;
  logic [GOUT-1:0]        w_max;
  logic                   w_first;
  logic                   w_write;
  logic                   w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    w_first = 1'b0;
    w_write = 1'b0;
    w_last  = (r_wr_idx == LAST);
    if (!load) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_first = 1'b1;
          w_next  = S_RUN;
        end
        S_RUN: begin
          w_write = 1'b1;
          if (w_last) w_next = S_DONE;
        end
        S_DONE:  w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  assign w_sel = w_first ? '0 : r_rd_idx;
  assign w_grp = d[int'(w_sel)*GIN +: GIN];

  // rd_idx saturates at G-1 instead of reaching G, so the counter never wraps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_idx <= '0;
      r_wr_idx <= '0;
      r_stage  <= '0;
      r_q      <= '0;
      r_valid  <= 1'b0;
    end else if (!load) begin
      r_rd_idx <= '0;
      r_wr_idx <= '0;
      r_valid  <= 1'b0;
    end else if (w_first) begin
      r_stage  <= w_grp;
      r_rd_idx <= RD_START;
      r_wr_idx <= '0;
    end else if (w_write) begin
      r_q[int'(r_wr_idx)*GOUT +: GOUT] <= w_max;
      if (w_last) begin
        r_valid <= 1'b1;
      end else begin
        r_wr_idx <= r_wr_idx + CW'(1);
        r_stage  <= w_grp;
        if (r_rd_idx != LAST) r_rd_idx <= r_rd_idx + CW'(1);
      end
    end
  end

  for (genvar c = 0; c < CPC; c++) begin : g_ch
    for (genvar k = 0; k < PLEN; k++) begin : g_pos
      max2 u_max2 (
        .i_a   (r_stage[(c*LEN+2*k)*DL +: DL]),
        .i_b   (r_stage[(c*LEN+2*k+1)*DL +: DL]),
        .o_max (w_max[(c*PLEN+k)*DL +: DL])
      );
    end
  end

  assign valid = r_valid;
  assign q     = r_q;

endmodule

// File: tb/tb_maxpool_layer.sv
// Bench for maxpool_layer: CPC=4 main instance plus CPC=1 and CPC=32 variants.
module tb_maxpool_layer;
  import maxpool_layer_pkg::*;

  localparam int DW   = CH * LEN * DL;
  localparam int QW   = CH * PLEN * DL;
  localparam int GOUT = 4 * PLEN * DL;
  localparam int NV   = 9;

  typedef struct {
    logic signed [DL-1:0] a;
    logic signed [DL-1:0] b;
    logic signed [DL-1:0] e;
  } vec_t;

  logic          clk, rst, load;
  logic [DW-1:0] d;
  logic          valid4, valid1, valid32;
  logic [QW-1:0] q4, q1, q32;

  vec_t          tbl [NV];
  logic [QW-1:0] sb [$];
  int            checks = 0;
  int            errors = 0;

  maxpool_layer #(.CPC(4))  dut   (.clk(clk), .rst(rst), .load(load), .d(d), .valid(valid4),  .q(q4));
  maxpool_layer #(.CPC(1))  dut1  (.clk(clk), .rst(rst), .load(load), .d(d), .valid(valid1),  .q(q1));
  maxpool_layer #(.CPC(32)) dut32 (.clk(clk), .rst(rst), .load(load), .d(d), .valid(valid32), .q(q32));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_q(input string nm, input logic [QW-1:0] act, input logic [QW-1:0] exp);
    logic signed [DL-1:0] ga, ge;
    checks++;
    if (act !== exp) begin
      errors++;
      for (int c = 0; c < CH; c++)
        for (int k = 0; k < PLEN; k++) begin
          ga = act[(c*PLEN+k)*DL +: DL];
          ge = exp[(c*PLEN+k)*DL +: DL];
          if (ga !== ge) begin
            $display("FAIL %s: q(%0d,%0d) got %0d expected %0d", nm, c, k, ga, ge);
            return;
          end
        end
    end
  endtask

  function automatic logic [DW-1:0] mk_ramp();
    logic [DW-1:0] r = '0;
    for (int c = 0; c < CH; c++)
      for (int p = 0; p < LEN; p++) r[(c*LEN+p)*DL +: DL] = DL'(c*LEN + p);
    return r;
  endfunction

  function automatic logic [QW-1:0] exp_ramp();
    logic [QW-1:0] r = '0;
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < PLEN; k++) r[(c*PLEN+k)*DL +: DL] = DL'(c*LEN + 2*k + 1);
    return r;
  endfunction

  function automatic logic [DW-1:0] mk_rand();
    logic [DW-1:0] r = '0;
    for (int i = 0; i < CH*LEN; i++) r[i*DL +: DL] = DL'($urandom);
    return r;
  endfunction

  function automatic logic [QW-1:0] ref_pool(input logic [DW-1:0] dd);
    logic [QW-1:0] r = '0;
    logic signed [DL-1:0] a, b;
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < PLEN; k++) begin
        a = dd[(c*LEN+2*k)*DL +: DL];
        b = dd[(c*LEN+2*k+1)*DL +: DL];
        r[(c*PLEN+k)*DL +: DL] = (a > b) ? a : b;
      end
    return r;
  endfunction

  task automatic set_vec(input int i, input int a, input int b, input int e);
    tbl[i].a = DL'(a);
    tbl[i].b = DL'(b);
    tbl[i].e = DL'(e);
  endtask

  // Slots k=0..2 of every channel carry the fixed signed/tie pattern.
  task automatic build_table(output logic [DW-1:0] dd, output logic [QW-1:0] qq);
    int v;
    dd = '0;
    qq = '0;
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < PLEN; k++) begin
        v = (k < 3) ? k : 3 + (c*3 + k - 3) % (NV - 3);
        dd[(c*LEN+2*k)*DL +: DL]   = tbl[v].a;
        dd[(c*LEN+2*k+1)*DL +: DL] = tbl[v].b;
        qq[(c*PLEN+k)*DL +: DL]    = tbl[v].e;
      end
  endtask

  task automatic run4(input string nm);
    int lat = 0;
    load = 1'b1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (valid4) begin
        lat = n;
        break;
      end
    end
    chk({nm, " latency"}, lat, 9);
    if (sb.size() > 0) chk_q({nm, " q"}, q4, sb.pop_front());
    else chk({nm, " scoreboard empty"}, 0, 1);
  endtask

  task automatic drop_load();
    load = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    logic [DW-1:0] dd, dd2;
    logic [QW-1:0] qt, qr, qe;
    int l4, l1, l32;

    set_vec(0, -5, -3, -3);
    set_vec(1, -1, 0, 0);
    set_vec(2, -7, -7, -7);
    set_vec(3, 3, -3, 3);
    set_vec(4, 32767, -32768, 32767);
    set_vec(5, -32768, -32767, -32767);
    set_vec(6, 0, 0, 0);
    set_vec(7, 100, 101, 101);
    set_vec(8, -1, -32768, -1);

    rst = 1'b1; load = 1'b0; d = '0;
    #12;
    chk("reset valid", 32'(valid4), 0);
    chk_q("reset q", q4, '0);
    chk("reset valid cpc32", 32'(valid32), 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    // Ramp across all three channel widths
    d = mk_ramp();
    load = 1'b1;
    l4 = 0; l1 = 0; l32 = 0;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (valid4  && l4  == 0) l4  = n;
      if (valid1  && l1  == 0) l1  = n;
      if (valid32 && l32 == 0) l32 = n;
      if (l4 != 0 && l1 != 0 && l32 != 0) break;
    end
    chk("ramp latency cpc4", l4, 9);
    chk("ramp latency cpc1", l1, 33);
    chk("ramp latency cpc32", l32, 2);
    chk_q("ramp q cpc4", q4, exp_ramp());
    chk_q("ramp q cpc1", q1, exp_ramp());
    chk_q("ramp q cpc32", q32, exp_ramp());
    chk("ramp valid held", 32'(valid4), 1);
    drop_load();

    // Signed table, then hold through edge 20
    build_table(dd, qt);
    d = dd;
    sb.push_back(qt);
    run4("signed");
    for (int n = 10; n <= 20; n++) begin
      @(posedge clk); #1;
      chk($sformatf("hold valid edge %0d", n), 32'(valid4), 1);
    end
    chk_q("hold q", q4, qt);
    drop_load();
    chk("hold drop valid", 32'(valid4), 0);
    chk_q("hold drop q retained", q4, qt);

    // Abort after 4 edges: groups 0..2 new, 3..7 old
    dd = mk_rand();
    qr = ref_pool(dd);
    d = dd;
    load = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk); #1;
      chk($sformatf("abort valid edge %0d", n), 32'(valid4), 0);
    end
    drop_load();
    chk("abort valid", 32'(valid4), 0);
    qe = qt;
    qe[0 +: 3*GOUT] = qr[0 +: 3*GOUT];
    chk_q("abort partial q", q4, qe);
    sb.push_back(qr);
    run4("relaunch");
    drop_load();

    // Asynchronous reset mid-run
    dd2 = mk_rand();
    d = dd2;
    load = 1'b1;
    for (int n = 1; n <= 4; n++) begin
      @(posedge clk); #1;
    end
    #2 rst = 1'b1;
    #1;
    chk("rst valid", 32'(valid4), 0);
    chk("rst valid cpc32", 32'(valid32), 0);
    chk_q("rst q", q4, '0);
    load = 1'b0;
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    sb.push_back(ref_pool(dd2));
    run4("rerun");
    drop_load();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
